// File: rtl/game_2048_pkg.sv
// game_2048_pkg: constants shared by the 2048 drop-game core and its front end.
//   NUM_COLS / COL_W     : board width and column-index width.
//   CORE_DROP_LATENCY    : worst-case cycles the core needs to return to idle
//                          after accepting a drop request.
//   col_step()           : one cursor move left or right, saturating or wrapping.
package game_2048_pkg;

  localparam int NUM_COLS          = 4;
  localparam int COL_W             = 2;
  localparam int CORE_DROP_LATENCY = 7;

  typedef logic [COL_W-1:0] col_t;

  // Move the cursor one column; at the edge either hold or wrap to the far side.
  function automatic col_t col_step(input col_t col, input logic dir_right, input logic wrap);
    col_t res;
    res = col;
    if (dir_right) begin
      if (col == col_t'(NUM_COLS - 1)) begin
        res = wrap ? col_t'(0) : col;
      end else begin
        res = col + col_t'(1);
      end
    end else begin
      if (col == col_t'(0)) begin
        res = wrap ? col_t'(NUM_COLS - 1) : col;
      end else begin
        res = col - col_t'(1);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/drop_input_ctrl_if.sv
// drop_input_ctrl_if: player-side bundle between the button board and the
// drop-game core.
//   btn_left/btn_right/btn_drop : raw asynchronous push-buttons, active-high
//   game_over                   : core status, freezes input handling
//   col_sel                     : registered cursor column
//   drop_pulse                  : registered single-cycle drop request
// master = stimulus/board side, slave = drop_input_ctrl.
interface drop_input_ctrl_if;
  import game_2048_pkg::*;

  logic btn_left;
  logic btn_right;
  logic btn_drop;
  logic game_over;
  col_t col_sel;
  logic drop_pulse;

  modport master (
    output btn_left, btn_right, btn_drop, game_over,
    input  col_sel, drop_pulse
  );

  modport slave (
    input  btn_left, btn_right, btn_drop, game_over,
    output col_sel, drop_pulse
  );

endinterface

// File: rtl/drop_input_ctrl_btn_debounce.sv
// btn_debounce: one push-button path: 2-flop synchronizer, counting debouncer
// and rising-edge detector.
//   clk, rst  : system clock, synchronous active-high reset
//   btn_raw   : asynchronous raw button
//   level     : debounced button level
//   press     : one-cycle event on each debounced rising edge
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic             deb_dly_q, deb_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: the level only flips after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    deb_dly_d = deb_q;
    deb_d     = deb_q;
    cnt_d     = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
    end
  end

  assign level = deb_q;
  // Built from two flops only; consumers register the result.
  assign press = deb_q & ~deb_dly_q;

endmodule

// File: rtl/drop_input_ctrl.sv
// drop_input_ctrl: player-input front end of the 2048 drop game. Debounces the
// three buttons, keeps the cursor column and issues one-cycle drop requests
// separated by a holdoff long enough for the core to return to idle.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of drop_input_ctrl_if (buttons, game_over in;
//              col_sel, drop_pulse out, both registered)
module drop_input_ctrl
  import game_2048_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int DROP_GAP   = 8,
  parameter int WRAP       = 0
) (
  input  logic              clk,
  input  logic              rst,
  drop_input_ctrl_if.slave  bus
);

  localparam int HOLD_W = $clog2(DROP_GAP + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DROP_GAP);
  localparam logic WRAP_EN = (WRAP != 0);

  generate
    if (DROP_GAP < CORE_DROP_LATENCY) begin : g_gap_too_short
      $error("DROP_GAP shorter than the core drop-to-idle time");
    end
    if (DEB_CYCLES < 2) begin : g_deb_too_short
      $error("DEB_CYCLES must be at least 2");
    end
  endgenerate

  logic unused_left_level, unused_right_level, unused_drop_level;
  logic left_press, right_press, drop_press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_left),
    .level(unused_left_level), .press(left_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_right),
    .level(unused_right_level), .press(right_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_drop (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_drop),
    .level(unused_drop_level), .press(drop_press)
  );

  col_t              col_sel_q, col_sel_d;
  logic              drop_pulse_q, drop_pulse_d;
  logic [HOLD_W-1:0] holdoff_q, holdoff_d;

  // Event resolution: game_over > accepted drop > moves. An accepted drop
  // swallows same-cycle moves so col_sel is stable while drop_pulse is high;
  // a drop rejected by holdoff falls through so moves still apply.
  always_comb begin
    col_sel_d    = col_sel_q;
    drop_pulse_d = 1'b0;
    holdoff_d    = holdoff_q;
    if (holdoff_q != '0) begin
      holdoff_d = holdoff_q - HOLD_W'(1);
    end else begin
      holdoff_d = '0;
    end

    if (bus.game_over) begin
      col_sel_d = col_sel_q;
    end else if (drop_press && (holdoff_q == '0)) begin
      drop_pulse_d = 1'b1;
      holdoff_d    = HOLD_LOAD;
    end else if (left_press && right_press) begin
      col_sel_d = col_sel_q;
    end else if (left_press) begin
      col_sel_d = col_step(col_sel_q, 1'b0, WRAP_EN);
    end else if (right_press) begin
      col_sel_d = col_step(col_sel_q, 1'b1, WRAP_EN);
    end else begin
      col_sel_d = col_sel_q;
    end
  end

  // Cursor, holdoff and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_sel_q    <= '0;
      drop_pulse_q <= 1'b0;
      holdoff_q    <= '0;
    end else begin
      col_sel_q    <= col_sel_d;
      drop_pulse_q <= drop_pulse_d;
      holdoff_q    <= holdoff_d;
    end
  end

  assign bus.col_sel    = col_sel_q;
  assign bus.drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_drop_input_ctrl.sv
// tb_drop_input_ctrl: directed bench for drop_input_ctrl with DEB_CYCLES=4,
// DROP_GAP=8. Instance a uses WRAP=0, instance b uses WRAP=1.
module tb_drop_input_ctrl;

  logic clk;
  logic rst;

  drop_input_ctrl_if ifa();
  drop_input_ctrl_if ifb();

  drop_input_ctrl #(.DEB_CYCLES(4), .DROP_GAP(8), .WRAP(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  drop_input_ctrl #(.DEB_CYCLES(4), .DROP_GAP(8), .WRAP(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] btn;       // {drop, right, left}
    logic       go;
    int         exp_col;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[17];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int pulse_t[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n cycles, sampling outputs on the falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (ifa.drop_pulse === 1'b1) begin
        pulses_a++;
        pulse_t.push_back(cyc);
      end
      if (ifb.drop_pulse === 1'b1) pulses_b++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Press buttons on instance a long enough to debounce, release, let it settle.
  task automatic apply_a(input string name, input logic [2:0] btn, input logic go,
                         input int exp_col, input int exp_pulses);
    pulses_a = 0;
    ifa.game_over = go;
    ifa.btn_drop  = btn[2];
    ifa.btn_right = btn[1];
    ifa.btn_left  = btn[0];
    tick(8);
    ifa.btn_drop  = 1'b0;
    ifa.btn_right = 1'b0;
    ifa.btn_left  = 1'b0;
    tick(12);
    ifa.game_over = 1'b0;
    chk({name, " col"}, int'(ifa.col_sel), exp_col);
    chk({name, " pulses"}, pulses_a, exp_pulses);
  endtask

  task automatic apply_b(input string name, input logic [1:0] btn, input int exp_col);
    ifb.btn_right = btn[1];
    ifb.btn_left  = btn[0];
    tick(8);
    ifb.btn_right = 1'b0;
    ifb.btn_left  = 1'b0;
    tick(12);
    chk(name, int'(ifb.col_sel), exp_col);
  endtask

  // Drop held from now: pulse must appear only in the sample after edge e0+6.
  task automatic drop_latency(input string name);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk($sformatf("%s pulse@e%0d", name, k), int'(ifa.drop_pulse), (k == 6) ? 1 : 0);
    end
  endtask

  int diff;

  initial begin
    rst = 1'b1;
    ifa.btn_left = 1'b0; ifa.btn_right = 1'b0; ifa.btn_drop = 1'b0; ifa.game_over = 1'b0;
    ifb.btn_left = 1'b0; ifb.btn_right = 1'b0; ifb.btn_drop = 1'b0; ifb.game_over = 1'b0;

    vecs[0]  = '{3'b100, 1'b0, 0, 1};
    vecs[1]  = '{3'b010, 1'b0, 1, 0};
    vecs[2]  = '{3'b010, 1'b0, 2, 0};
    vecs[3]  = '{3'b010, 1'b0, 3, 0};
    vecs[4]  = '{3'b010, 1'b0, 3, 0};
    vecs[5]  = '{3'b010, 1'b0, 3, 0};
    vecs[6]  = '{3'b001, 1'b0, 2, 0};
    vecs[7]  = '{3'b001, 1'b0, 1, 0};
    vecs[8]  = '{3'b001, 1'b0, 0, 0};
    vecs[9]  = '{3'b001, 1'b0, 0, 0};
    vecs[10] = '{3'b001, 1'b0, 0, 0};
    vecs[11] = '{3'b010, 1'b0, 1, 0};
    vecs[12] = '{3'b011, 1'b0, 1, 0};  // left+right together
    vecs[13] = '{3'b010, 1'b0, 2, 0};
    vecs[14] = '{3'b110, 1'b0, 2, 1};  // drop+right same cycle
    vecs[15] = '{3'b101, 1'b1, 2, 0};  // game_over blocks drop/left
    vecs[16] = '{3'b001, 1'b0, 1, 0};

    do_reset();
    chk("reset col_a", int'(ifa.col_sel), 0);
    chk("reset pulse_a", int'(ifa.drop_pulse), 0);
    chk("reset col_b", int'(ifb.col_sel), 0);

    // Basic drop: one pulse after e6, none more while held.
    ifa.btn_drop = 1'b1;
    drop_latency("basic");
    chk("basic col", int'(ifa.col_sel), 0);
    pulses_a = 0;
    tick(100);
    chk("basic held no repeat", pulses_a, 0);
    ifa.btn_drop = 1'b0;
    tick(12);

    for (int i = 0; i < 17; i++) begin
      apply_a($sformatf("vec%0d", i), vecs[i].btn, vecs[i].go,
              vecs[i].exp_col, vecs[i].exp_pulses);
    end

    // Bounce rejection: 3-high/1-low bursts never debounce.
    do_reset();
    for (int r = 0; r < 5; r++) begin
      ifa.btn_right = 1'b1; tick(3);
      ifa.btn_right = 1'b0; tick(1);
    end
    ifa.btn_right = 1'b1; tick(10);
    ifa.btn_right = 1'b0; tick(12);
    chk("bounce col", int'(ifa.col_sel), 1);

    // Holdoff: drop events 8 cycles apart -> one pulse.
    pulses_a = 0;
    pulse_t.delete();
    ifa.btn_drop = 1'b1; tick(4);
    ifa.btn_drop = 1'b0; tick(4);
    ifa.btn_drop = 1'b1; tick(20);
    ifa.btn_drop = 1'b0; tick(12);
    chk("holdoff 8 pulses", pulses_a, 1);

    // Holdoff: events 9 cycles apart -> two pulses 9 cycles apart.
    pulses_a = 0;
    pulse_t.delete();
    ifa.btn_drop = 1'b1; tick(4);
    ifa.btn_drop = 1'b0; tick(5);
    ifa.btn_drop = 1'b1; tick(20);
    ifa.btn_drop = 1'b0; tick(12);
    chk("holdoff 9 pulses", pulses_a, 2);
    diff = (pulse_t.size() == 2) ? (pulse_t[1] - pulse_t[0]) : -1;
    chk("holdoff 9 spacing", diff, 9);

    // Reset one cycle after a pulse with drop still held.
    do_reset();
    apply_a("pre-rst right", 3'b010, 1'b0, 1, 0);
    ifa.btn_drop = 1'b1;
    drop_latency("pre-rst");
    rst = 1'b1;
    tick(1);
    chk("mid-rst col", int'(ifa.col_sel), 0);
    chk("mid-rst pulse", int'(ifa.drop_pulse), 0);
    rst = 1'b0;
    drop_latency("post-rst");
    pulses_a = 0;
    tick(30);
    chk("post-rst held no repeat", pulses_a, 0);
    ifa.btn_drop = 1'b0;
    tick(12);

    // Wrap instance.
    apply_b("wrap left 0->3", 2'b01, 3);
    apply_b("wrap right 3->0", 2'b10, 0);
    apply_b("wrap right 0->1", 2'b10, 1);
    chk("wrap no pulses", pulses_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
